// File: rtl/init_dump_router.sv
// init_dump_router: routes beats between the host AXI-Stream pair and NUM_CELLS cell channels.
// INIT steers host beats to a cell by TDEST; DUMP drains all cells, in order, back to the host.
module init_dump_router #(
   parameter int AXIS_TDATA_WIDTH = 512,
   parameter int TDEST_WIDTH      = 16,
   parameter int NUM_CELLS        = 4,
   parameter int CELL_ID_BASE     = 0,
   parameter int INVALID_BIT      = 226,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_init_start,
   input  logic                                  i_dump_start,
   output logic                                  o_busy,
   output logic                                  o_init_done,
   output logic                                  o_dump_done,
   input  logic                                  i_s_axis_h2k_tvalid,
   output logic                                  o_s_axis_h2k_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0]           i_s_axis_h2k_tdata,
   input  logic                                  i_s_axis_h2k_tlast,
   input  logic [TDEST_WIDTH-1:0]                i_s_axis_h2k_tdest,
   output logic [NUM_CELLS-1:0]                  o_m_axis_k2pc_tvalid,
   input  logic [NUM_CELLS-1:0]                  i_m_axis_k2pc_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]           o_m_axis_k2pc_tdata,
   input  logic [NUM_CELLS-1:0]                  i_s_axis_pc2k_tvalid,
   input  logic [NUM_CELLS-1:0]                  i_s_axis_pc2k_tlast,
   output logic [NUM_CELLS-1:0]                  o_s_axis_pc2k_tready,
   input  logic [NUM_CELLS*AXIS_TDATA_WIDTH-1:0] i_s_axis_pc2k_tdata,
   output logic                                  o_m_axis_k2h_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0]           o_m_axis_k2h_tdata,
   output logic                                  o_m_axis_k2h_tlast,
   input  logic                                  i_m_axis_k2h_tready,
   output logic [CNT_WIDTH-1:0]                  o_routed_count,
   output logic [CNT_WIDTH-1:0]                  o_dropped_count
);
   localparam int W    = AXIS_TDATA_WIDTH;
   localparam int CH_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_INIT_DRAIN, S_DUMP, S_DUMP_TERM, S_DUMP_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [NUM_CELLS-1:0] pc_valid_q, pc_valid_d;
   logic [W-1:0]         pc_data_q, pc_data_d;
   logic                 h_valid_q, h_valid_d;
   logic                 h_last_q, h_last_d;
   logic [W-1:0]         h_data_q, h_data_d;
   logic [CNT_WIDTH-1:0] routed_q, routed_d, dropped_q, dropped_d;
   logic                 init_done_q, init_done_d, dump_done_q, dump_done_d;

   logic                 pc_free, h_free, h2k_accept, dest_hit;
   logic [TDEST_WIDTH:0] dest_off;
   logic [NUM_CELLS-1:0] dest_onehot, pc_ready_vec;
   logic [W-1:0]         cell_data [NUM_CELLS];
   logic [W-1:0]         src_data;
   logic                 src_valid, src_last, src_accept, last_ch, src_invalid;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A slice is free when empty or when its current beat handshakes this cycle.
   assign pc_free    = !(|pc_valid_q) || (|(pc_valid_q & i_m_axis_k2pc_tready));
   assign h_free     = !h_valid_q || i_m_axis_k2h_tready;
   assign h2k_accept = (state_q == S_INIT) && pc_free && i_s_axis_h2k_tvalid;
   // One extra bit keeps TDEST values below CELL_ID_BASE from wrapping into range.
   assign dest_off   = {1'b0, i_s_axis_h2k_tdest} - (TDEST_WIDTH+1)'(CELL_ID_BASE);

   generate
      for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
         assign dest_onehot[gi]  = (dest_off == (TDEST_WIDTH+1)'(gi));
         assign pc_ready_vec[gi] = (state_q == S_DUMP) && h_free && (ch_q == CH_W'(gi));
         assign cell_data[gi]    = i_s_axis_pc2k_tdata[gi*W +: W];
      end
   endgenerate

   assign dest_hit    = |dest_onehot;
   assign src_data    = cell_data[ch_q];
   assign src_valid   = i_s_axis_pc2k_tvalid[ch_q];
   assign src_last    = i_s_axis_pc2k_tlast[ch_q];
   assign src_invalid = src_data[INVALID_BIT];
   assign src_accept  = (state_q == S_DUMP) && h_free && src_valid;
   assign last_ch     = (ch_q == CH_W'(NUM_CELLS-1));

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      pc_valid_d  = pc_valid_q & ~i_m_axis_k2pc_tready;
      pc_data_d   = pc_data_q;
      h_valid_d   = h_valid_q && !i_m_axis_k2h_tready;
      h_data_d    = h_data_q;
      h_last_d    = h_last_q && !i_m_axis_k2h_tready;
      routed_d    = routed_q;
      dropped_d   = dropped_q;
      init_done_d = 1'b0;
      dump_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_init_start) begin
               state_d   = S_INIT;
               routed_d  = '0;
               dropped_d = '0;
            end else if (i_dump_start) begin
               state_d   = S_DUMP;
               ch_d      = '0;
               routed_d  = '0;
               dropped_d = '0;
            end
         end
         S_INIT: begin
            if (h2k_accept) begin
               if (dest_hit) begin
                  pc_valid_d = dest_onehot;
                  pc_data_d  = i_s_axis_h2k_tdata;
                  routed_d   = sat_inc(routed_q);
               end else begin
                  dropped_d  = sat_inc(dropped_q);
               end
               if (i_s_axis_h2k_tlast)
                  state_d = S_INIT_DRAIN;
            end
         end
         S_INIT_DRAIN: begin
            if (pc_valid_d == '0) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
            end
         end
         S_DUMP: begin
            if (src_accept) begin
               if (!src_invalid) begin
                  h_valid_d = 1'b1;
                  h_data_d  = src_data;
                  h_last_d  = last_ch && src_last;
                  routed_d  = sat_inc(routed_q);
               end else begin
                  dropped_d = sat_inc(dropped_q);
               end
               if (src_last) begin
                  if (!last_ch) begin
                     ch_d = ch_q + 1'b1;
                  end else begin
                     ch_d    = '0;
                     state_d = src_invalid ? S_DUMP_TERM : S_DUMP_DRAIN;
                  end
               end
            end
         end
         S_DUMP_TERM: begin
            // The host still needs a tlast, so emit an all-zero terminator beat.
            if (h_free) begin
               h_valid_d = 1'b1;
               h_data_d  = '0;
               h_last_d  = 1'b1;
               state_d   = S_DUMP_DRAIN;
            end
         end
         S_DUMP_DRAIN: begin
            if (h_valid_q && h_last_q && i_m_axis_k2h_tready) begin
               state_d     = S_IDLE;
               dump_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         pc_valid_q  <= '0;
         pc_data_q   <= '0;
         h_valid_q   <= 1'b0;
         h_data_q    <= '0;
         h_last_q    <= 1'b0;
         routed_q    <= '0;
         dropped_q   <= '0;
         init_done_q <= 1'b0;
         dump_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         pc_valid_q  <= pc_valid_d;
         pc_data_q   <= pc_data_d;
         h_valid_q   <= h_valid_d;
         h_data_q    <= h_data_d;
         h_last_q    <= h_last_d;
         routed_q    <= routed_d;
         dropped_q   <= dropped_d;
         init_done_q <= init_done_d;
         dump_done_q <= dump_done_d;
      end
   end

   assign o_busy               = (state_q != S_IDLE);
   assign o_init_done          = init_done_q;
   assign o_dump_done          = dump_done_q;
   assign o_s_axis_h2k_tready  = (state_q == S_INIT) && pc_free;
   assign o_m_axis_k2pc_tvalid = pc_valid_q;
   assign o_m_axis_k2pc_tdata  = pc_data_q;
   assign o_s_axis_pc2k_tready = pc_ready_vec;
   assign o_m_axis_k2h_tvalid  = h_valid_q;
   assign o_m_axis_k2h_tdata   = h_data_q;
   assign o_m_axis_k2h_tlast   = h_last_q;
   assign o_routed_count       = routed_q;
   assign o_dropped_count      = dropped_q;

endmodule

// File: tb/tb_init_dump_router.sv
// Directed bench for init_dump_router: INIT routing/dropping/backpressure, DUMP ordering,
// invalid-beat filtering, terminator insertion and mid-dump reset.
`timescale 1ns/1ps
module tb_init_dump_router;
   localparam int W  = 512;
   localparam int NC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              i_init_start, i_dump_start;
   logic              o_busy, o_init_done, o_dump_done;
   logic              h2k_tvalid, h2k_tready, h2k_tlast;
   logic [W-1:0]      h2k_tdata;
   logic [15:0]       h2k_tdest;
   logic [NC-1:0]     k2pc_tvalid, k2pc_tready;
   logic [W-1:0]      k2pc_tdata;
   logic [NC-1:0]     pc2k_tvalid, pc2k_tlast, pc2k_tready;
   logic [NC*W-1:0]   pc2k_tdata;
   logic              k2h_tvalid, k2h_tlast, k2h_tready;
   logic [W-1:0]      k2h_tdata;
   logic [31:0]       routed, dropped;

   init_dump_router dut (
      .clk(clk), .rst(rst),
      .i_init_start(i_init_start), .i_dump_start(i_dump_start),
      .o_busy(o_busy), .o_init_done(o_init_done), .o_dump_done(o_dump_done),
      .i_s_axis_h2k_tvalid(h2k_tvalid), .o_s_axis_h2k_tready(h2k_tready),
      .i_s_axis_h2k_tdata(h2k_tdata), .i_s_axis_h2k_tlast(h2k_tlast),
      .i_s_axis_h2k_tdest(h2k_tdest),
      .o_m_axis_k2pc_tvalid(k2pc_tvalid), .i_m_axis_k2pc_tready(k2pc_tready),
      .o_m_axis_k2pc_tdata(k2pc_tdata),
      .i_s_axis_pc2k_tvalid(pc2k_tvalid), .i_s_axis_pc2k_tlast(pc2k_tlast),
      .o_s_axis_pc2k_tready(pc2k_tready), .i_s_axis_pc2k_tdata(pc2k_tdata),
      .o_m_axis_k2h_tvalid(k2h_tvalid), .o_m_axis_k2h_tdata(k2h_tdata),
      .o_m_axis_k2h_tlast(k2h_tlast), .i_m_axis_k2h_tready(k2h_tready),
      .o_routed_count(routed), .o_dropped_count(dropped)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Cell-side sources: per-channel beat tables replayed on handshake.
   logic [W-1:0] src_mem [NC][8];
   int           src_len [NC];
   int           src_idx [NC];
   logic         src_en;
   logic [NC-1:0] src_hs;

   generate
      for (genvar gi = 0; gi < NC; gi++) begin : g_src
         assign pc2k_tvalid[gi]          = src_en && (src_idx[gi] < src_len[gi]);
         assign pc2k_tlast[gi]           = (src_idx[gi] == src_len[gi] - 1);
         assign pc2k_tdata[gi*W +: W]    = src_mem[gi][src_idx[gi] % 8];
      end
   endgenerate

   initial begin
      forever begin
         @(posedge clk); #1;
         for (int c = 0; c < NC; c++) if (src_hs[c]) src_idx[c]++;
      end
   end

   logic ready_rand = 1'b0;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ready_rand) k2h_tready = 1'($urandom_range(0, 1));
      end
   end

   // Handshake monitors, sampled mid-cycle.
   logic [W-1:0] pc_q_data [$];
   int           pc_q_ch [$];
   int           pc_q_cyc [$];
   logic [W-1:0] h_q_data [$];
   logic         h_q_last [$];
   int           h_q_cyc [$];
   int           acc_cyc [$];
   int           init_done_cnt = 0, dump_done_cnt = 0;
   int           init_done_cyc = 0, dump_done_cyc = 0;
   logic         prev_stall = 1'b0, prev_last = 1'b0;
   logic [W-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (h2k_tvalid && h2k_tready) acc_cyc.push_back(cyc);
      for (int c = 0; c < NC; c++) begin
         if (k2pc_tvalid[c] && k2pc_tready[c]) begin
            pc_q_data.push_back(k2pc_tdata);
            pc_q_ch.push_back(c);
            pc_q_cyc.push_back(cyc);
         end
      end
      if (k2h_tvalid && k2h_tready) begin
         h_q_data.push_back(k2h_tdata);
         h_q_last.push_back(k2h_tlast);
         h_q_cyc.push_back(cyc);
      end
      if (o_init_done) begin init_done_cnt++; init_done_cyc = cyc; end
      if (o_dump_done) begin dump_done_cnt++; dump_done_cyc = cyc; end
      if (prev_stall && !rst) begin
         check("k2h_hold_valid", W'(k2h_tvalid), W'(1));
         check("k2h_hold_data", k2h_tdata, prev_data);
         check("k2h_hold_last", W'(k2h_tlast), W'(prev_last));
      end
      prev_stall = k2h_tvalid && !k2h_tready && !rst;
      prev_data  = k2h_tdata;
      prev_last  = k2h_tlast;
      src_hs     = pc2k_tvalid & pc2k_tready;
   end

   task automatic clear_queues();
      pc_q_data.delete(); pc_q_ch.delete(); pc_q_cyc.delete();
      h_q_data.delete(); h_q_last.delete(); h_q_cyc.delete(); acc_cyc.delete();
   endtask

   task automatic pulse_start(input bit ini, input bit dmp);
      @(posedge clk); #1;
      i_init_start = ini;
      i_dump_start = dmp;
      @(posedge clk); #1;
      i_init_start = 1'b0;
      i_dump_start = 1'b0;
      check("busy_after_start", W'(o_busy), W'(1));
   endtask

   task automatic h2k_send(input logic [W-1:0] d, input logic [15:0] dest, input logic last);
      int n = 0;
      h2k_tvalid = 1'b1;
      h2k_tdata  = d;
      h2k_tdest  = dest;
      h2k_tlast  = last;
      @(negedge clk);
      while (!h2k_tready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("h2k_timeout", W'(h2k_tready), W'(1));
      @(posedge clk); #1;
      h2k_tvalid = 1'b0;
      h2k_tlast  = 1'b0;
   endtask

   task automatic wait_done(input bit is_dump);
      int n = 0;
      int start = is_dump ? dump_done_cnt : init_done_cnt;
      while (((is_dump ? dump_done_cnt : init_done_cnt) == start) && n < 500) begin
         @(negedge clk); n++;
      end
      repeat (3) @(negedge clk);
      check(is_dump ? "dump_done_pulses" : "init_done_pulses",
            W'((is_dump ? dump_done_cnt : init_done_cnt) - start), W'(1));
   endtask

   logic [W-1:0] exp_data [$];
   logic         exp_last [$];
   logic [W-1:0] inv;

   task automatic load_set_a();
      for (int c = 0; c < NC; c++) begin
         src_len[c] = 2;
         for (int k = 0; k < 2; k++) src_mem[c][k] = W'(c * 256 + k + 1);
      end
      src_mem[1][0] = W'(12'h101) | inv;
      exp_data.delete(); exp_last.delete();
      exp_data = '{W'(12'h001), W'(12'h002), W'(12'h102), W'(12'h201),
                   W'(12'h202), W'(12'h301), W'(12'h302)};
      exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   endtask

   task automatic run_dump(input int exp_routed, input int exp_dropped, input bit rnd);
      int last_cyc;
      clear_queues();
      for (int c = 0; c < NC; c++) src_idx[c] = 0;
      src_en = 1'b1;
      ready_rand = rnd;
      pulse_start(1'b0, 1'b1);
      wait_done(1'b1);
      ready_rand = 1'b0;
      k2h_tready = 1'b1;
      src_en = 1'b0;
      check("dump_beats", W'(h_q_data.size()), W'(exp_data.size()));
      for (int i = 0; i < exp_data.size() && i < h_q_data.size(); i++) begin
         check($sformatf("dump_data%0d", i), h_q_data[i], exp_data[i]);
         check($sformatf("dump_last%0d", i), W'(h_q_last[i]), W'(exp_last[i]));
      end
      last_cyc = (h_q_cyc.size() > 0) ? h_q_cyc[h_q_cyc.size()-1] : -100;
      check("dump_done_latency", W'(dump_done_cyc - last_cyc), W'(1));
      check("dump_routed", W'(routed), W'(exp_routed));
      check("dump_dropped", W'(dropped), W'(exp_dropped));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int last_cyc;
      inv = '0;
      inv[226] = 1'b1;
      rst = 1'b1;
      i_init_start = 1'b0; i_dump_start = 1'b0;
      h2k_tvalid = 1'b0; h2k_tdata = '0; h2k_tlast = 1'b0; h2k_tdest = '0;
      k2pc_tready = '1; k2h_tready = 1'b1;
      src_en = 1'b0; src_hs = '0;
      for (int c = 0; c < NC; c++) begin
         src_len[c] = 0; src_idx[c] = 0;
         for (int k = 0; k < 8; k++) src_mem[c][k] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", W'(o_busy), W'(0));
      check("rst_k2pc_valid", W'(k2pc_tvalid), W'(0));
      check("rst_k2h_valid", W'(k2h_tvalid), W'(0));
      check("rst_k2h_last", W'(k2h_tlast), W'(0));
      check("rst_h2k_ready", W'(h2k_tready), W'(0));
      check("rst_pc2k_ready", W'(pc2k_tready), W'(0));
      check("rst_routed", W'(routed), W'(0));
      check("rst_dropped", W'(dropped), W'(0));
      check("rst_done", W'({o_init_done, o_dump_done}), W'(0));
      @(posedge clk); #1 rst = 1'b0;

      // INIT: TDEST 0..3, both starts high -> INIT wins
      clear_queues();
      pulse_start(1'b1, 1'b1);
      check("init_priority_ready", W'(h2k_tready), W'(1));
      for (int i = 0; i < 4; i++) h2k_send(W'(32'hA000 + i), 16'(i), (i == 3));
      wait_done(1'b0);
      check("t1_beats", W'(pc_q_data.size()), W'(4));
      for (int i = 0; i < 4 && i < pc_q_data.size(); i++) begin
         check($sformatf("t1_ch%0d", i), W'(pc_q_ch[i]), W'(i));
         check($sformatf("t1_data%0d", i), pc_q_data[i], W'(32'hA000 + i));
      end
      check("t1_latency", W'((pc_q_cyc.size() > 0 ? pc_q_cyc[0] : -100) -
                             (acc_cyc.size() > 0 ? acc_cyc[0] : 0)), W'(1));
      last_cyc = (pc_q_cyc.size() > 0) ? pc_q_cyc[pc_q_cyc.size()-1] : -100;
      check("t1_done_latency", W'(init_done_cyc - last_cyc), W'(1));
      check("t1_routed", W'(routed), W'(4));
      check("t1_dropped", W'(dropped), W'(0));
      check("t1_idle", W'(o_busy), W'(0));

      // INIT: out-of-range TDESTs dropped around a beat to channel 2
      clear_queues();
      pulse_start(1'b1, 1'b0);
      h2k_send(W'(32'hB007), 16'd7, 1'b0);
      h2k_send(W'(32'hB002), 16'd2, 1'b0);
      h2k_send(W'(32'hBFFF), 16'hFFFF, 1'b1);
      wait_done(1'b0);
      check("t2_beats", W'(pc_q_data.size()), W'(1));
      check("t2_ch", W'(pc_q_ch.size() > 0 ? pc_q_ch[0] : -1), W'(2));
      check("t2_data", pc_q_data.size() > 0 ? pc_q_data[0] : '0, W'(32'hB002));
      check("t2_routed", W'(routed), W'(1));
      check("t2_dropped", W'(dropped), W'(2));

      // INIT: channel 1 backpressure for 5 cycles
      clear_queues();
      k2pc_tready = 4'b1101;
      pulse_start(1'b1, 1'b0);
      fork
         begin
            h2k_send(W'(32'hC001), 16'd1, 1'b0);
            h2k_send(W'(32'hC002), 16'd2, 1'b0);
            h2k_send(W'(32'hC003), 16'd3, 1'b1);
         end
         begin
            n = 0;
            @(negedge clk);
            while (!k2pc_tvalid[1] && n < 100) begin @(negedge clk); n++; end
            check("t3_valid_seen", W'(k2pc_tvalid[1]), W'(1));
            repeat (5) begin
               check("t3_h2k_ready_low", W'(h2k_tready), W'(0));
               check("t3_hold_valid", W'(k2pc_tvalid), W'(4'b0010));
               check("t3_hold_data", k2pc_tdata, W'(32'hC001));
               @(negedge clk);
            end
            @(posedge clk); #1 k2pc_tready = '1;
         end
      join
      wait_done(1'b0);
      check("t3_beats", W'(pc_q_data.size()), W'(3));
      for (int i = 0; i < 3 && i < pc_q_data.size(); i++) begin
         check($sformatf("t3_ch%0d", i), W'(pc_q_ch[i]), W'(i + 1));
         check($sformatf("t3_data%0d", i), pc_q_data[i], W'(32'hC001 + i));
      end
      check("t3_routed", W'(routed), W'(3));

      // DUMP: 2 beats per channel, channel 1 beat 0 invalid, random host ready
      load_set_a();
      run_dump(7, 1, 1'b1);

      // DUMP: last channel's tlast beat invalid -> zero terminator
      for (int c = 0; c < NC; c++) begin
         src_len[c] = 1;
         src_mem[c][0] = W'(c * 256 + 1);
      end
      src_mem[3][0] = W'(12'h301) | inv;
      exp_data = '{W'(12'h001), W'(12'h101), W'(12'h201), W'(0)};
      exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
      run_dump(3, 0 + 1, 1'b0);

      // Reset during DUMP with the host slice full
      load_set_a();
      clear_queues();
      k2h_tready = 1'b0;
      for (int c = 0; c < NC; c++) src_idx[c] = 0;
      src_en = 1'b1;
      pulse_start(1'b0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!k2h_tvalid && n < 100) begin @(negedge clk); n++; end
      check("t6_slice_full", W'(k2h_tvalid), W'(1));
      check("t6_routed_before", W'(routed), W'(1));
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t6_k2h_valid", W'(k2h_tvalid), W'(0));
      check("t6_k2pc_valid", W'(k2pc_tvalid), W'(0));
      check("t6_pc2k_ready", W'(pc2k_tready), W'(0));
      check("t6_busy", W'(o_busy), W'(0));
      check("t6_routed", W'(routed), W'(0));
      src_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 k2h_tready = 1'b1;
      run_dump(7, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/init_dump_router.md
# init_dump_router

Host-side distribution/collection router between the host AXI-Stream pair (h2k/k2h) and NUM_CELLS position-cache channels. In INIT mode it steers each host beat to the cell channel selected by TDEST and drops beats addressed elsewhere. In DUMP mode it drains every cell channel in ascending order back to the host, discarding beats whose invalid flag is set. All paths use full valid/ready handshakes through single-entry registered slices.

## Interface
- AXIS_TDATA_WIDTH, 512, beat width on every stream
- TDEST_WIDTH, 16, host TDEST width
- NUM_CELLS, 4, number of cell channels (≥1)
- CELL_ID_BASE, 0, TDEST of cell channel 0; channel c owns TDEST CELL_ID_BASE+c
- INVALID_BIT, 226, tdata bit index flagging an empty/invalid particle record
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_init_start  in  1  start INIT (sampled in IDLE only)
- i_dump_start  in  1  start DUMP (sampled in IDLE only; init has priority if both high)
- o_busy  out  1  high in any state except IDLE
- o_init_done / o_dump_done  out  1  one-cycle completion pulses
- i_s_axis_h2k_tvalid/tready(out)/tdata/tlast/tdest  in  1/1/W/1/TDEST_WIDTH  host input stream
- o_m_axis_k2pc_tvalid  out  NUM_CELLS  per-channel valid (one-hot or zero)
- i_m_axis_k2pc_tready  in  NUM_CELLS  per-channel ready
- o_m_axis_k2pc_tdata  out  W  shared data to all channels
- i_s_axis_pc2k_tvalid/tlast  in  NUM_CELLS each  cell dump streams
- o_s_axis_pc2k_tready  out  NUM_CELLS  one-hot ready to the channel being drained
- i_s_axis_pc2k_tdata  in  NUM_CELLS*W  flattened, channel c at [c*W +: W]
- o_m_axis_k2h_tvalid/tdata/tlast, i_m_axis_k2h_tready  out/out/out/in  1/W/1/1  host output stream
- o_routed_count, o_dropped_count  out  CNT_WIDTH each  statistics

## Operation
- FSM states: IDLE, INIT, INIT_DRAIN, DUMP, DUMP_TERM, DUMP_DRAIN.
- IDLE: all tready low. Start inputs are ignored in every other state.
- INIT: h2k_tready = !pc_valid_any || i_m_axis_k2pc_tready[held channel]. An accepted beat with TDEST−CELL_ID_BASE in [0, NUM_CELLS) loads the slice: tdata registered, tvalid bit set for that channel, routed_count+1. Other TDESTs are accepted and discarded, dropped_count+1. Accepting a beat with tlast → INIT_DRAIN.
- INIT_DRAIN: h2k_tready low. When the slice is empty → IDLE, pulse o_init_done.
- DUMP: channel pointer ch starts at 0; o_s_axis_pc2k_tready[ch] = !k2h_valid || i_m_axis_k2h_tready. Per accepted beat:
  - INVALID_BIT clear: load the k2h slice, routed_count+1; tlast = (ch==NUM_CELLS−1 && source tlast).
  - INVALID_BIT set: discard, dropped_count+1.
  - Source tlast on ch<NUM_CELLS−1: ch+1.
  - Source tlast on the last channel: → DUMP_DRAIN if that beat was forwarded, else → DUMP_TERM.
- DUMP_TERM: once the slice is free, load a terminator (tdata all zero, tlast 1, not counted) → DUMP_DRAIN.
- DUMP_DRAIN: after the tlast beat handshakes → IDLE, pulse o_dump_done.
- Counters clear when either start is accepted and saturate at all-ones.
- Slice rule: once valid, an output holds data/tlast stable until ready is seen.

## Timing
- Reset: FSM IDLE, ch=0, all tvalid/tready/tlast outputs 0, tdata outputs 0, counters 0, done pulses 0, o_busy 0.
- Latency: 1 cycle from input handshake to output valid. Back-to-back throughput is 1 beat/cycle when the downstream ready stays high.
- A start pulse in IDLE moves the FSM to INIT or DUMP on the next edge. tready may rise that same next cycle.
- Simultaneous load and unload of a slice in one cycle is legal; the new beat replaces the old one.
- rst mid-transfer aborts immediately: valid drops and any beat in a slice is lost.
- Dropped beats still need the slice to be free (tready), so the accepted order is preserved.

## Test plan
- INIT, NUM_CELLS=4, TDEST 0,1,2,3 with ready high → channels 0..3 each see one beat 1 cycle after acceptance; routed=4, dropped=0; o_init_done 1 cycle after the last output.
- INIT, TDEST 7 and 0xFFFF interleaved with TDEST 2, tlast on the final beat → only channel 2 sees valid; dropped=2; o_init_done still pulses.
- INIT, channel 1 ready held low for 5 cycles → h2k_tready low and data stable for those 5 cycles, no beat lost, order preserved.
- DUMP, each channel 2 beats, bit 226 set on channel 1 beat 0 → host receives 7 beats in order, tlast on channel 3 beat 1; dropped=1.
- DUMP, bit 226 set on the last channel's tlast beat → zero terminator beat with tlast=1 follows; o_dump_done pulses after its handshake.
- rst asserted during DUMP with the k2h slice full → next cycle all valid outputs 0, IDLE, counters 0; a new dump then runs cleanly.
